// File: rtl/cr_iu_branch_pkg.sv
// -----------------------------------------------------------------------------
// cr_iu_branch_pkg
// Shared types for the IU branch resolution unit and its return-address stack:
//   - ex_op_e   : branch-class opcode encoding presented on ex_op
//   - ras_act_e : per-cycle RAS action (none / push / pop / replace top)
//   - is_jump / is_cond / is_link : opcode class helpers
// -----------------------------------------------------------------------------
package cr_iu_branch_pkg;

    localparam int OP_W  = 4;
    localparam int ACT_W = 2;

    typedef enum logic [OP_W-1:0] {
        BEQ   = 4'd0,
        BNE   = 4'd1,
        BLT   = 4'd2,
        BGE   = 4'd3,
        BLTU  = 4'd4,
        BGEU  = 4'd5,
        CBEQZ = 4'd6,
        CBNEZ = 4'd7,
        JAL   = 4'd8,
        JALR  = 4'd9,
        CJ    = 4'd10,
        CJAL  = 4'd11,
        CJR   = 4'd12,
        CJALR = 4'd13
    } ex_op_e;

    typedef enum logic [ACT_W-1:0] {
        RAS_NONE = 2'd0,
        RAS_PUSH = 2'd1,
        RAS_POP  = 2'd2,
        RAS_REPL = 2'd3
    } ras_act_e;

    // Unconditional change of flow.
    function automatic logic is_jump(input ex_op_e op);
        return op inside {JAL, JALR, CJ, CJAL, CJR, CJALR};
    endfunction

    // Conditional branch, taken only when its compare succeeds.
    function automatic logic is_cond(input ex_op_e op);
        return op inside {BEQ, BNE, BLT, BGE, BLTU, BGEU, CBEQZ, CBNEZ};
    endfunction

    // Ops that write a return address to rd.
    function automatic logic is_link(input ex_op_e op);
        return op inside {JAL, JALR, CJAL, CJALR};
    endfunction

endpackage

// File: rtl/cr_iu_ras.sv
// -----------------------------------------------------------------------------
// cr_iu_ras
// Circular return-address stack with a top pointer and a saturating count.
// A push when full overwrites the oldest entry. A pop when empty is ignored.
// Replace-top on an empty stack degenerates to a push (pop is a no-op).
// Ports:
//   forever_cpuclk, cpurst : clock, synchronous active-high reset
//   ras_act                : action for this cycle (already qualified)
//   push_pc                : return address [XLEN-1:1] to push / replace with
//   top_pc, top_vld        : current top entry (0 when empty) and non-empty flag
// -----------------------------------------------------------------------------
module cr_iu_ras
    import cr_iu_branch_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic            forever_cpuclk,
    input  logic            cpurst,
    input  ras_act_e        ras_act,
    input  logic [XLEN-1:1] push_pc,
    output logic [XLEN-1:1] top_pc,
    output logic            top_vld
);

    localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam logic [PTR_W:0] CNT_MAX = (PTR_W+1)'(RAS_DEPTH);

    logic [XLEN-1:1] mem [RAS_DEPTH];
    logic [PTR_W-1:0] ptr_p1, ptr_nxt;
    logic [PTR_W:0]   cnt_p1, cnt_nxt;
    logic             wr_en;
    logic [PTR_W-1:0] wr_idx;
    logic             grow;

    always_comb begin
        ptr_nxt = ptr_p1;
        cnt_nxt = cnt_p1;
        wr_en   = 1'b0;
        wr_idx  = ptr_p1;
        grow    = 1'b0;
        case (ras_act)
            RAS_PUSH: grow = 1'b1;
            RAS_POP: begin
                if (cnt_p1 != '0) begin
                    ptr_nxt = ptr_p1 - PTR_W'(1);
                    cnt_nxt = cnt_p1 - (PTR_W+1)'(1);
                end
            end
            RAS_REPL: begin
                if (cnt_p1 == '0) begin
                    grow = 1'b1;
                end else begin
                    wr_en  = 1'b1;
                    wr_idx = ptr_p1;
                end
            end
            default: ;
        endcase
        if (grow) begin
            // Pointer wraps naturally because RAS_DEPTH is a power of two.
            ptr_nxt = ptr_p1 + PTR_W'(1);
            wr_en   = 1'b1;
            wr_idx  = ptr_p1 + PTR_W'(1);
            cnt_nxt = (cnt_p1 == CNT_MAX) ? cnt_p1 : cnt_p1 + (PTR_W+1)'(1);
        end
    end

    // ---- stage p1: pointer/count state ----
    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            ptr_p1 <= '0;
            cnt_p1 <= '0;
        end else begin
            ptr_p1 <= ptr_nxt;
            cnt_p1 <= cnt_nxt;
        end
    end

    always_ff @(posedge forever_cpuclk) begin
        if (wr_en) begin
            mem[wr_idx] <= push_pc;
        end
    end

    assign top_vld = (cnt_p1 != '0);
    // Entries are not reset, so mask the top while empty.
    assign top_pc  = top_vld ? mem[ptr_p1] : '0;

endmodule

// File: rtl/cr_iu_branch_ras.sv
// -----------------------------------------------------------------------------
// cr_iu_branch_ras
// IU execute-stage branch/jump resolution with a registered redirect request
// to pcgen and an integrated return-address stack.
// Ports:
//   forever_cpuclk, cpurst        : clock, synchronous active-high reset
//   ex_vld, ex_op, ex_inst_32bit  : branch-class instruction in EX
//   ex_pc [XLEN-1:1]              : its PC
//   ex_rs1, ex_rs2, ex_imm        : operands and sign-extended offset
//   ex_rd_link, ex_rs1_link       : rd / rs1 is x1 or x5
//   flush                         : pipeline flush (wins over everything)
//   ex_stall                      : EX must hold the branch this cycle
//   link_vld, link_data           : combinational return-address write
//   redir_vld, redir_pc, redir_rdy: change-of-flow handshake to pcgen
//   ras_pred_vld, ras_pred_pc     : RAS top-of-stack prediction
//   ras_ret_vld, ras_ret_hit      : return seen / matched prediction (pulse)
// -----------------------------------------------------------------------------
module cr_iu_branch_ras
    import cr_iu_branch_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic            forever_cpuclk,
    input  logic            cpurst,
    input  logic            ex_vld,
    input  logic [OP_W-1:0] ex_op,
    input  logic            ex_inst_32bit,
    input  logic [XLEN-1:1] ex_pc,
    input  logic [XLEN-1:0] ex_rs1,
    input  logic [XLEN-1:0] ex_rs2,
    input  logic [XLEN-1:0] ex_imm,
    input  logic            ex_rd_link,
    input  logic            ex_rs1_link,
    input  logic            flush,
    output logic            ex_stall,
    output logic            link_vld,
    output logic [XLEN-1:0] link_data,
    output logic            redir_vld,
    output logic [XLEN-1:1] redir_pc,
    input  logic            redir_rdy,
    output logic            ras_pred_vld,
    output logic [XLEN-1:1] ras_pred_pc,
    output logic            ras_ret_vld,
    output logic            ras_ret_hit
);

    ex_op_e                 op;
    logic [XLEN-1:0]        cmp_b;
    logic signed [XLEN:0]   cmp_a_s;
    logic signed [XLEN:0]   cmp_b_s;
    logic                   eq, lt, ltu, cond_true;
    logic                   cof, accept;
    logic [XLEN-1:1]        pc_tgt, jalr_tgt, reg_tgt, cof_tgt, link_pc;
    ras_act_e               ras_act;
    logic [XLEN-1:1]        ras_top;
    logic                   ras_top_vld;
    logic                   redir_vld_p1, ras_ret_vld_p1, ras_ret_hit_p1;
    logic [XLEN-1:1]        redir_pc_p1;

    assign op = ex_op_e'(ex_op);

    // ---- stage p0: compare, target and link datapath ----
    assign cmp_b   = (op == CBEQZ || op == CBNEZ) ? '0 : ex_rs2;
    // Sign-extend to XLEN+1 bits so the signed compare cannot overflow.
    assign cmp_a_s = $signed({ex_rs1[XLEN-1], ex_rs1});
    assign cmp_b_s = $signed({cmp_b[XLEN-1], cmp_b});
    assign eq      = (ex_rs1 == cmp_b);
    assign lt      = (cmp_a_s < cmp_b_s);
    assign ltu     = (ex_rs1 < cmp_b);

    always_comb begin
        cond_true = 1'b0;
        case (op)
            BEQ, CBEQZ: cond_true = eq;
            BNE, CBNEZ: cond_true = !eq;
            BLT:        cond_true = lt;
            BGE:        cond_true = !lt;
            BLTU:       cond_true = ltu;
            BGEU:       cond_true = !ltu;
            default:    cond_true = 1'b0;
        endcase
    end

    assign cof = is_jump(op) || (is_cond(op) && cond_true);

    // Targets are kept as [XLEN-1:1]. pc has bit0 = 0, so pc+imm never
    // carries out of bit0; rs1+imm does when both low bits are set.
    assign pc_tgt   = ex_pc + ex_imm[XLEN-1:1];
    assign jalr_tgt = ex_rs1[XLEN-1:1] + ex_imm[XLEN-1:1]
                    + {{(XLEN-2){1'b0}}, ex_rs1[0] & ex_imm[0]};
    assign reg_tgt  = ex_rs1[XLEN-1:1];

    always_comb begin
        case (op)
            JALR:       cof_tgt = jalr_tgt;
            CJR, CJALR: cof_tgt = reg_tgt;
            default:    cof_tgt = pc_tgt;
        endcase
    end

    assign link_pc   = ex_pc + (ex_inst_32bit ? (XLEN-1)'(2) : (XLEN-1)'(1));
    assign link_data = {link_pc, 1'b0};

    assign ex_stall = ex_vld && redir_vld_p1 && !redir_rdy;
    assign accept   = ex_vld && !ex_stall && !flush;
    assign link_vld = accept && is_link(op);

    always_comb begin
        ras_act = RAS_NONE;
        if (accept) begin
            case (op)
                JAL, CJAL: begin
                    if (ex_rd_link) ras_act = RAS_PUSH;
                end
                JALR, CJALR: begin
                    if (ex_rd_link && ex_rs1_link)       ras_act = RAS_REPL;
                    else if (ex_rd_link)                 ras_act = RAS_PUSH;
                    else if (op == JALR && ex_rs1_link)  ras_act = RAS_POP;
                end
                CJR: begin
                    if (ex_rs1_link && !ex_rd_link) ras_act = RAS_POP;
                end
                default: ras_act = RAS_NONE;
            endcase
        end
    end

    cr_iu_ras #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .forever_cpuclk (forever_cpuclk),
        .cpurst         (cpurst),
        .ras_act        (ras_act),
        .push_pc        (link_pc),
        .top_pc         (ras_top),
        .top_vld        (ras_top_vld)
    );

    // ---- stage p1: redirect request and return-prediction result ----
    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            redir_vld_p1 <= 1'b0;
            redir_pc_p1  <= '0;
        end else if (flush) begin
            redir_vld_p1 <= 1'b0;
        end else if (accept && cof) begin
            // Also covers rdy && new change of flow: back-to-back requests.
            redir_vld_p1 <= 1'b1;
            redir_pc_p1  <= cof_tgt;
        end else if (redir_rdy) begin
            redir_vld_p1 <= 1'b0;
        end
    end

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            ras_ret_vld_p1 <= 1'b0;
            ras_ret_hit_p1 <= 1'b0;
        end else begin
            ras_ret_vld_p1 <= (ras_act == RAS_POP);
            ras_ret_hit_p1 <= (ras_act == RAS_POP) && ras_top_vld && (cof_tgt == ras_top);
        end
    end

    assign redir_vld    = redir_vld_p1;
    assign redir_pc     = redir_pc_p1;
    assign ras_ret_vld  = ras_ret_vld_p1;
    assign ras_ret_hit  = ras_ret_hit_p1;
    assign ras_pred_vld = ras_top_vld;
    assign ras_pred_pc  = ras_top;

endmodule

// File: tb/tb_cr_iu_branch_ras.sv
module tb_cr_iu_branch_ras;
    import cr_iu_branch_pkg::*;

    localparam int XLEN      = 32;
    localparam int RAS_DEPTH = 4;

    logic            clk = 1'b0;
    logic            cpurst;
    logic            ex_vld;
    logic [3:0]      ex_op;
    logic            ex_inst_32bit;
    logic [XLEN-1:1] ex_pc;
    logic [XLEN-1:0] ex_rs1, ex_rs2, ex_imm;
    logic            ex_rd_link, ex_rs1_link, flush;
    logic            ex_stall, link_vld;
    logic [XLEN-1:0] link_data;
    logic            redir_vld;
    logic [XLEN-1:1] redir_pc;
    logic            redir_rdy;
    logic            ras_pred_vld;
    logic [XLEN-1:1] ras_pred_pc;
    logic            ras_ret_vld, ras_ret_hit;

    always #5 clk = ~clk;

    cr_iu_branch_ras #(.XLEN(XLEN), .RAS_DEPTH(RAS_DEPTH)) dut (
        .forever_cpuclk (clk),
        .cpurst         (cpurst),
        .ex_vld         (ex_vld),
        .ex_op          (ex_op),
        .ex_inst_32bit  (ex_inst_32bit),
        .ex_pc          (ex_pc),
        .ex_rs1         (ex_rs1),
        .ex_rs2         (ex_rs2),
        .ex_imm         (ex_imm),
        .ex_rd_link     (ex_rd_link),
        .ex_rs1_link    (ex_rs1_link),
        .flush          (flush),
        .ex_stall       (ex_stall),
        .link_vld       (link_vld),
        .link_data      (link_data),
        .redir_vld      (redir_vld),
        .redir_pc       (redir_pc),
        .redir_rdy      (redir_rdy),
        .ras_pred_vld   (ras_pred_vld),
        .ras_pred_pc    (ras_pred_pc),
        .ras_ret_vld    (ras_ret_vld),
        .ras_ret_hit    (ras_ret_hit)
    );

    typedef struct {
        logic        vld;
        ex_op_e      op;
        logic [31:0] pc, rs1, rs2, imm;
        logic        is32, rdl, rs1l, rdy, fl;
    } stim_t;

    typedef struct {
        logic        rv;
        logic [31:1] rpc;
        logic        ret_vld, ret_hit;
        logic        pv;
        logic [31:1] ppc;
    } exp_t;

    int total = 0;
    int bad   = 0;

    exp_t        sb[$];
    exp_t        e;
    logic [31:0] m_ras[$];
    logic        m_rv;
    logic [31:1] m_rpc;
    logic        m_stall, m_lvld, a_stall, a_lvld;
    logic [31:0] m_ldata, a_ldata;

    function automatic stim_t mk(logic vld, ex_op_e op, logic [31:0] pc, logic [31:0] rs1,
                                 logic [31:0] rs2, logic [31:0] imm, logic is32, logic rdl,
                                 logic rs1l, logic rdy, logic fl);
        stim_t s;
        s.vld = vld; s.op = op; s.pc = pc; s.rs1 = rs1; s.rs2 = rs2; s.imm = imm;
        s.is32 = is32; s.rdl = rdl; s.rs1l = rs1l; s.rdy = rdy; s.fl = fl;
        return s;
    endfunction

    // Drive one cycle, run the reference model, push expected results.
    task automatic run_stim(input stim_t s);
        logic [31:0] b, tgt, lnk;
        logic tk, acc, push, pop, repl, hit;
        exp_t x;
        ex_vld = s.vld; ex_op = s.op; ex_pc = s.pc[31:1];
        ex_rs1 = s.rs1; ex_rs2 = s.rs2; ex_imm = s.imm; ex_inst_32bit = s.is32;
        ex_rd_link = s.rdl; ex_rs1_link = s.rs1l; redir_rdy = s.rdy; flush = s.fl;
        #1;
        b = (s.op == CBEQZ || s.op == CBNEZ) ? 32'd0 : s.rs2;
        case (s.op)
            BEQ, CBEQZ: tk = (s.rs1 == b);
            BNE, CBNEZ: tk = (s.rs1 != b);
            BLT:        tk = ($signed(s.rs1) <  $signed(b));
            BGE:        tk = ($signed(s.rs1) >= $signed(b));
            BLTU:       tk = (s.rs1 <  b);
            BGEU:       tk = (s.rs1 >= b);
            default:    tk = 1'b1;
        endcase
        case (s.op)
            JALR:       tgt = s.rs1 + s.imm;
            CJR, CJALR: tgt = s.rs1;
            default:    tgt = s.pc + s.imm;
        endcase
        tgt[0] = 1'b0;
        lnk = s.pc + (s.is32 ? 32'd4 : 32'd2);
        m_stall = s.vld && m_rv && !s.rdy;
        acc = s.vld && !m_stall && !s.fl;
        m_lvld = acc && (s.op inside {JAL, JALR, CJAL, CJALR});
        m_ldata = lnk;
        push = 1'b0; pop = 1'b0; repl = 1'b0;
        if (acc) begin
            case (s.op)
                JAL, CJAL: push = s.rdl;
                JALR, CJALR: begin
                    repl = s.rdl && s.rs1l;
                    push = s.rdl && !s.rs1l;
                    pop  = (s.op == JALR) && s.rs1l && !s.rdl;
                end
                CJR: pop = s.rs1l && !s.rdl;
                default: ;
            endcase
        end
        hit = pop && (m_ras.size() > 0) && (m_ras[m_ras.size()-1] == tgt);
        if (pop && m_ras.size() > 0) void'(m_ras.pop_back());
        if (repl && m_ras.size() > 0) m_ras[m_ras.size()-1] = lnk;
        else if (push || repl) begin
            m_ras.push_back(lnk);
            if (m_ras.size() > RAS_DEPTH) void'(m_ras.pop_front());
        end
        if (s.fl) m_rv = 1'b0;
        else if (acc && tk) begin m_rv = 1'b1; m_rpc = tgt[31:1]; end
        else if (s.rdy) m_rv = 1'b0;
        x.rv = m_rv; x.rpc = m_rpc; x.ret_vld = acc && pop; x.ret_hit = hit;
        x.pv = (m_ras.size() > 0);
        x.ppc = (m_ras.size() > 0) ? m_ras[m_ras.size()-1][31:1] : 31'd0;
        sb.push_back(x);
        a_stall = ex_stall; a_lvld = link_vld; a_ldata = link_data;
        @(posedge clk); #1;
    endtask

    function automatic stim_t idle();
        return mk(1'b0, BEQ, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    endfunction

    task automatic test_reset();
        ex_vld = 0; ex_op = 0; ex_pc = '0; ex_rs1 = '0; ex_rs2 = '0; ex_imm = '0;
        ex_inst_32bit = 1; ex_rd_link = 0; ex_rs1_link = 0; flush = 0; redir_rdy = 1;
        cpurst = 1;
        repeat (2) @(posedge clk);
        #1 cpurst = 0;
        m_rv = 0; m_rpc = '0; m_ras.delete(); sb.delete();
        total++; if (redir_vld !== 1'b0) begin bad++; $display("FAIL reset redir_vld got %b want 0", redir_vld); end
        total++; if (redir_pc !== 31'd0) begin bad++; $display("FAIL reset redir_pc got %h want 0", redir_pc); end
        total++; if (ras_ret_vld !== 1'b0) begin bad++; $display("FAIL reset ras_ret_vld got %b want 0", ras_ret_vld); end
        total++; if (ras_ret_hit !== 1'b0) begin bad++; $display("FAIL reset ras_ret_hit got %b want 0", ras_ret_hit); end
        total++; if (ras_pred_vld !== 1'b0) begin bad++; $display("FAIL reset ras_pred_vld got %b want 0", ras_pred_vld); end
        total++; if (ras_pred_pc !== 31'd0) begin bad++; $display("FAIL reset ras_pred_pc got %h want 0", ras_pred_pc); end
        total++; if (ex_stall !== 1'b0) begin bad++; $display("FAIL reset ex_stall got %b want 0", ex_stall); end
    endtask

    task automatic test_branches();
        stim_t t[$];
        t.push_back(mk(1, BEQ,   32'h100, 32'd5,        32'd5,        32'h20,       1, 0, 0, 1, 0));
        t.push_back(mk(1, BNE,   32'h100, 32'd5,        32'd5,        32'h20,       1, 0, 0, 1, 0));
        t.push_back(mk(1, BLT,   32'h140, 32'hFFFFFFFF, 32'd1,        32'h8,        1, 0, 0, 1, 0));
        t.push_back(mk(1, BLTU,  32'h160, 32'hFFFFFFFF, 32'd1,        32'h8,        1, 0, 0, 1, 0));
        t.push_back(mk(1, CBEQZ, 32'h180, 32'd0,        32'd7,        32'hFFFFFFFC, 0, 0, 0, 1, 0));
        t.push_back(mk(1, BGE,   32'h1A0, 32'd1,        32'hFFFFFFFF, 32'h11,       1, 0, 0, 1, 0));
        t.push_back(mk(1, BGEU,  32'h1C0, 32'd1,        32'hFFFFFFFF, 32'h40,       1, 0, 0, 1, 0));
        t.push_back(idle());
        foreach (t[i]) begin
            run_stim(t[i]);
            e = sb.pop_front();
            total++; if (a_stall !== m_stall) begin bad++; $display("FAIL branch[%0d] ex_stall got %b want %b", i, a_stall, m_stall); end
            total++; if (redir_vld !== e.rv) begin bad++; $display("FAIL branch[%0d] redir_vld got %b want %b", i, redir_vld, e.rv); end
            total++; if (redir_pc !== e.rpc) begin bad++; $display("FAIL branch[%0d] redir_pc got %h want %h", i, redir_pc, e.rpc); end
        end
    endtask

    task automatic test_link_ret();
        stim_t t[$];
        t.push_back(mk(1, JAL,   32'h200, 32'h0,   32'h0, 32'h40, 1, 1, 0, 1, 0));
        t.push_back(mk(1, JALR,  32'h240, 32'h204, 32'h0, 32'h0,  1, 0, 1, 1, 0));
        t.push_back(mk(1, CJAL,  32'h250, 32'h0,   32'h0, 32'h10, 0, 1, 0, 1, 0));
        t.push_back(mk(1, CJALR, 32'h260, 32'h252, 32'h0, 32'h0,  0, 1, 1, 1, 0));
        t.push_back(mk(1, CJR,   32'h270, 32'h262, 32'h0, 32'h0,  0, 0, 1, 1, 0));
        t.push_back(idle());
        foreach (t[i]) begin
            run_stim(t[i]);
            e = sb.pop_front();
            total++; if (a_lvld !== m_lvld) begin bad++; $display("FAIL link[%0d] link_vld got %b want %b", i, a_lvld, m_lvld); end
            if (m_lvld) begin
                total++; if (a_ldata !== m_ldata) begin bad++; $display("FAIL link[%0d] link_data got %h want %h", i, a_ldata, m_ldata); end
            end
            total++; if (redir_vld !== e.rv || redir_pc !== e.rpc) begin bad++; $display("FAIL link[%0d] redir got %b/%h want %b/%h", i, redir_vld, redir_pc, e.rv, e.rpc); end
            total++; if (ras_ret_vld !== e.ret_vld) begin bad++; $display("FAIL link[%0d] ras_ret_vld got %b want %b", i, ras_ret_vld, e.ret_vld); end
            total++; if (ras_ret_hit !== e.ret_hit) begin bad++; $display("FAIL link[%0d] ras_ret_hit got %b want %b", i, ras_ret_hit, e.ret_hit); end
            total++; if (ras_pred_vld !== e.pv || ras_pred_pc !== e.ppc) begin bad++; $display("FAIL link[%0d] ras_pred got %b/%h want %b/%h", i, ras_pred_vld, ras_pred_pc, e.pv, e.ppc); end
        end
    endtask

    task automatic test_ras_overflow();
        stim_t t[$];
        for (int i = 0; i < 6; i++)
            t.push_back(mk(1, CJAL, 32'h1000 + 32'h20*i, 32'h0, 32'h0, 32'h100, 0, 1, 0, 1, 0));
        for (int j = 0; j < 4; j++)
            t.push_back(mk(1, CJR, 32'h2000, 32'h1000 + 32'h20*(5-j) + 32'h2, 32'h0, 32'h0, 0, 0, 1, 1, 0));
        t.push_back(mk(1, CJR, 32'h2000, 32'h1002, 32'h0, 32'h0, 0, 0, 1, 1, 0));
        t.push_back(idle());
        foreach (t[i]) begin
            run_stim(t[i]);
            e = sb.pop_front();
            total++; if (ras_pred_vld !== e.pv) begin bad++; $display("FAIL ras[%0d] ras_pred_vld got %b want %b", i, ras_pred_vld, e.pv); end
            total++; if (ras_pred_pc !== e.ppc) begin bad++; $display("FAIL ras[%0d] ras_pred_pc got %h want %h", i, ras_pred_pc, e.ppc); end
            total++; if (ras_ret_vld !== e.ret_vld) begin bad++; $display("FAIL ras[%0d] ras_ret_vld got %b want %b", i, ras_ret_vld, e.ret_vld); end
            total++; if (ras_ret_hit !== e.ret_hit) begin bad++; $display("FAIL ras[%0d] ras_ret_hit got %b want %b", i, ras_ret_hit, e.ret_hit); end
        end
    endtask

    task automatic test_back_to_back();
        stim_t t[$];
        t.push_back(mk(1, BEQ, 32'h300, 32'd1, 32'd1, 32'h10, 1, 0, 0, 0, 0));
        for (int k = 0; k < 3; k++)
            t.push_back(mk(1, BNE, 32'h310, 32'd1, 32'd2, 32'h30, 1, 0, 0, 0, 0));
        t.push_back(mk(1, BNE, 32'h310, 32'd1, 32'd2, 32'h30, 1, 0, 0, 1, 0));
        t.push_back(mk(1, JAL, 32'h400, 32'h0, 32'h0, 32'h80, 1, 0, 0, 1, 0));
        t.push_back(idle());
        foreach (t[i]) begin
            run_stim(t[i]);
            e = sb.pop_front();
            total++; if (a_stall !== m_stall) begin bad++; $display("FAIL b2b[%0d] ex_stall got %b want %b", i, a_stall, m_stall); end
            total++; if (redir_vld !== e.rv) begin bad++; $display("FAIL b2b[%0d] redir_vld got %b want %b", i, redir_vld, e.rv); end
            total++; if (redir_pc !== e.rpc) begin bad++; $display("FAIL b2b[%0d] redir_pc got %h want %h", i, redir_pc, e.rpc); end
        end
    endtask

    task automatic test_flush();
        stim_t t[$];
        t.push_back(mk(1, JAL,  32'h500, 32'h0, 32'h0, 32'h10, 1, 1, 0, 0, 0));
        t.push_back(mk(1, CJAL, 32'h600, 32'h0, 32'h0, 32'h20, 0, 1, 0, 1, 1));
        t.push_back(mk(1, BEQ,  32'h620, 32'd3, 32'd3, 32'h8,  1, 0, 0, 0, 0));
        t.push_back(mk(0, BEQ,  32'h0,   32'h0, 32'h0, 32'h0,  1, 0, 0, 0, 1));
        t.push_back(idle());
        foreach (t[i]) begin
            run_stim(t[i]);
            e = sb.pop_front();
            total++; if (a_lvld !== m_lvld) begin bad++; $display("FAIL flush[%0d] link_vld got %b want %b", i, a_lvld, m_lvld); end
            total++; if (redir_vld !== e.rv || redir_pc !== e.rpc) begin bad++; $display("FAIL flush[%0d] redir got %b/%h want %b/%h", i, redir_vld, redir_pc, e.rv, e.rpc); end
            total++; if (ras_pred_vld !== e.pv || ras_pred_pc !== e.ppc) begin bad++; $display("FAIL flush[%0d] ras_pred got %b/%h want %b/%h", i, ras_pred_vld, ras_pred_pc, e.pv, e.ppc); end
        end
    endtask

    task automatic test_reset_mid();
        run_stim(mk(1, JAL, 32'h700, 32'h0, 32'h0, 32'h40, 1, 1, 0, 0, 0));
        e = sb.pop_front();
        total++; if (redir_vld !== e.rv) begin bad++; $display("FAIL rstmid pre redir_vld got %b want %b", redir_vld, e.rv); end
        cpurst = 1;
        @(posedge clk); #1 cpurst = 0;
        m_rv = 0; m_rpc = '0; m_ras.delete();
        total++; if (redir_vld !== 1'b0) begin bad++; $display("FAIL rstmid redir_vld got %b want 0", redir_vld); end
        total++; if (ras_pred_vld !== 1'b0) begin bad++; $display("FAIL rstmid ras_pred_vld got %b want 0", ras_pred_vld); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_branches();
        test_link_ret();
        test_ras_overflow();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
